// File: rtl/uart_bus_bridge_if.sv
// Signal bundle between the UART-to-bus bridge and its surroundings
// (UART receiver/sender, bus arbiter and the peripheral bus).
interface uart_bus_bridge_if;
  logic        rx_flag;
  logic [7:0]  rx_data;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        tx_work;
  logic        bus_req;
  logic        bus_gnt;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    input  rx_flag, rx_data, tx_work, bus_gnt, rdata,
    output tx_en, tx_data, bus_req, rd, wr, addr, wdata
  );

  modport slave (
    output rx_flag, rx_data, tx_work, bus_gnt, rdata,
    input  tx_en, tx_data, bus_req, rd, wr, addr, wdata
  );
endinterface

// File: rtl/uart_bus_bridge.sv
// Debug/load bus initiator: parses UART command bytes into single-word bus
// reads and writes and streams the result back through the UART sender.
module uart_bus_bridge #(
  parameter logic [31:0] TIMEOUT  = 32'd5000000,
  parameter logic [7:0]  ACK_BYTE = 8'h4B,
  parameter logic [7:0]  ERR_BYTE = 8'h3F
) (
  input  logic            clk,
  input  logic            reset,
  uart_bus_bridge_if.master bus
);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, REQ, BUS, RESP, ERR} state_t;
  typedef enum logic [1:0] {TX_WAIT, TX_REQ, TX_BUSY} tx_phase_t;

  state_t      state, state_next;
  tx_phase_t   tx_phase;
  logic        op_write;
  logic [1:0]  byte_cnt;
  logic [1:0]  tx_idx;
  logic [31:0] timeout_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rsp;
  logic        rx_prev;

  logic        rx_byte;
  logic        timeout_hit;
  logic        tx_last;
  logic        bus_fire;
  logic        tx_en;
  logic [7:0]  tx_data;
  logic        bus_req;
  logic        rd;
  logic        wr;

  assign rx_byte     = bus.rx_flag && !rx_prev;
  assign timeout_hit = (timeout_cnt == TIMEOUT - 32'd1);
  assign tx_last     = (state == ERR) || op_write || (tx_idx == 2'd3);
  // A grant that vanishes in BUS sends the bridge back to REQ without a strobe.
  assign bus_fire    = (state == BUS) && bus.bus_gnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (rx_byte) state_next = (bus.rx_data == 8'h57 || bus.rx_data == 8'h52) ? ADDR : ERR;
      ADDR: begin
        if (rx_byte && byte_cnt == 2'd3) state_next = op_write ? DATA : REQ;
        else if (!rx_byte && timeout_hit) state_next = IDLE;
      end
      DATA: begin
        if (rx_byte && byte_cnt == 2'd3) state_next = REQ;
        else if (!rx_byte && timeout_hit) state_next = IDLE;
      end
      REQ:  if (bus.bus_gnt) state_next = BUS;
      BUS:  state_next = bus.bus_gnt ? RESP : REQ;
      RESP, ERR: if (tx_phase == TX_BUSY && !bus.tx_work && tx_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_en   = 1'b0;
    tx_data = 8'h00;
    bus_req = 1'b0;
    rd      = 1'b0;
    wr      = 1'b0;
    case (state)
      REQ: bus_req = 1'b1;
      BUS: begin
        bus_req = 1'b1;
        rd      = bus.bus_gnt && !op_write;
        wr      = bus.bus_gnt && op_write;
      end
      RESP: begin
        tx_en = (tx_phase == TX_REQ) && !bus.tx_work;
        if (op_write) tx_data = ACK_BYTE;
        else begin
          case (tx_idx)
            2'd0:    tx_data = rsp[31:24];
            2'd1:    tx_data = rsp[23:16];
            2'd2:    tx_data = rsp[15:8];
            default: tx_data = rsp[7:0];
          endcase
        end
      end
      ERR: begin
        tx_en   = (tx_phase == TX_REQ) && !bus.tx_work;
        tx_data = ERR_BYTE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_prev     <= 1'b0;
      op_write    <= 1'b0;
      byte_cnt    <= 2'd0;
      timeout_cnt <= 32'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      rsp         <= 32'd0;
      tx_phase    <= TX_WAIT;
      tx_idx      <= 2'd0;
    end else begin
      rx_prev <= bus.rx_flag;
      case (state)
        IDLE: begin
          byte_cnt    <= 2'd0;
          timeout_cnt <= 32'd0;
          tx_phase    <= TX_WAIT;
          tx_idx      <= 2'd0;
          if (rx_byte) op_write <= (bus.rx_data == 8'h57);
        end
        ADDR, DATA: begin
          if (rx_byte) begin
            if (state == ADDR) addr_q  <= {addr_q[23:0], bus.rx_data};
            else               wdata_q <= {wdata_q[23:0], bus.rx_data};
            byte_cnt    <= byte_cnt + 2'd1;
            timeout_cnt <= 32'd0;
          end else if (timeout_hit) begin
            byte_cnt    <= 2'd0;
            timeout_cnt <= 32'd0;
          end else begin
            timeout_cnt <= timeout_cnt + 32'd1;
          end
        end
        BUS: begin
          tx_phase <= TX_WAIT;
          tx_idx   <= 2'd0;
          if (bus_fire && !op_write) rsp <= bus.rdata;
        end
        // Per byte: wait for an idle sender, request, then ride out its busy period.
        RESP, ERR: begin
          case (tx_phase)
            TX_WAIT: if (!bus.tx_work) tx_phase <= TX_REQ;
            TX_REQ:  if (bus.tx_work) tx_phase <= TX_BUSY;
            TX_BUSY: if (!bus.tx_work) begin
              tx_phase <= TX_REQ;
              tx_idx   <= tx_idx + 2'd1;
            end
            default: tx_phase <= TX_WAIT;
          endcase
        end
        default: ;
      endcase
    end
  end

  assign bus.tx_en   = tx_en;
  assign bus.tx_data = tx_data;
  assign bus.bus_req = bus_req;
  assign bus.rd      = rd;
  assign bus.wr      = wr;
  assign bus.addr    = addr_q;
  assign bus.wdata   = wdata_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Randomized bench for uart_bus_bridge: drives UART command bytes, models the
// arbiter, sender and bus memory, and compares against a protocol-level model.
`timescale 1ns/1ps
module tb_uart_bus_bridge;

  localparam logic [31:0] TO   = 32'd1000;
  localparam logic [7:0]  ACK  = 8'h4B;
  localparam logic [7:0]  ERRB = 8'h3F;

  logic clk = 1'b0;
  logic reset = 1'b0;

  uart_bus_bridge_if bif();

  uart_bus_bridge #(.TIMEOUT(TO), .ACK_BYTE(ACK), .ERR_BYTE(ERRB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.master)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rdata_val = 32'h0;
  assign bif.rdata = bif.rd ? rdata_val : 32'h0;

  int tx_delay  = 0;
  int tx_busy   = 3;
  int gnt_delay = 0;
  bit gnt_tied  = 1'b1;
  int arb_cnt   = 0;
  int req_wait  = 0;

  logic [7:0]  tx_q[$];
  bit          mon_wr_q[$];
  logic [31:0] mon_addr_q[$];
  logic [31:0] mon_wdata_q[$];
  logic [7:0]  cmd_q[$];

  logic [7:0]  exp_tx_q[$];
  bit          exp_bus;
  bit          exp_wr;
  logic [31:0] exp_addr;
  logic [31:0] exp_wdata;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Bus monitor: every strobe must be granted, exclusive, and is logged.
  always @(negedge clk) begin
    if (reset) begin
      if (bif.bus_req && !bif.bus_gnt) req_wait++;
      if (bif.rd || bif.wr) begin
        checkOutput("strobe_gnt", 32'(bif.bus_gnt), 32'd1);
        checkOutput("strobe_req", 32'(bif.bus_req), 32'd1);
        checkOutput("rd_wr_excl", 32'(bif.rd & bif.wr), 32'd0);
        mon_wr_q.push_back(bif.wr);
        mon_addr_q.push_back(bif.addr);
        mon_wdata_q.push_back(bif.wdata);
      end
    end
  end

  // Arbiter: grants after gnt_delay requesting cycles, or always when tied.
  initial begin
    bif.bus_gnt = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (gnt_tied) begin
        bif.bus_gnt = 1'b1;
        arb_cnt = 0;
      end else if (bif.bus_req) begin
        if (arb_cnt >= gnt_delay) bif.bus_gnt = 1'b1;
        arb_cnt++;
      end else begin
        bif.bus_gnt = 1'b0;
        arb_cnt = 0;
      end
    end
  end

  // Sender: accepts after tx_delay cycles, stays busy for tx_busy cycles.
  initial begin
    logic [7:0] b;
    bif.tx_work = 1'b0;
    forever begin
      @(negedge clk);
      if (reset && bif.tx_en) begin
        b = bif.tx_data;
        tx_q.push_back(b);
        repeat (tx_delay) begin
          @(negedge clk);
          checkOutput("tx_en_hold", 32'(bif.tx_en), 32'd1);
          checkOutput("tx_data_hold", 32'(bif.tx_data), 32'(b));
        end
        bif.tx_work = 1'b1;
        repeat (tx_busy) begin
          @(negedge clk);
          checkOutput("tx_en_drop", 32'(bif.tx_en), 32'd0);
          checkOutput("tx_data_busy", 32'(bif.tx_data), 32'(b));
        end
        bif.tx_work = 1'b0;
      end
    end
  end

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void build_model();
    exp_tx_q.delete();
    exp_bus = 1'b0; exp_wr = 1'b0; exp_addr = 32'h0; exp_wdata = 32'h0;
    if (cmd_q[0] == 8'h57 || cmd_q[0] == 8'h52) begin
      exp_bus = 1'b1;
      exp_wr  = (cmd_q[0] == 8'h57);
      for (int i = 1; i <= 4; i++) exp_addr = (exp_addr << 8) | 32'(cmd_q[i]);
      if (exp_wr) begin
        for (int i = 5; i <= 8; i++) exp_wdata = (exp_wdata << 8) | 32'(cmd_q[i]);
        exp_tx_q.push_back(ACK);
      end else begin
        for (int i = 0; i < 4; i++) exp_tx_q.push_back(8'((rdata_val >> (24 - 8 * i)) & 32'hFF));
      end
    end else begin
      exp_tx_q.push_back(ERRB);
    end
  endfunction

  task automatic make_cmd(input int kind, input logic [31:0] a, input logic [31:0] d);
    logic [7:0] bad;
    cmd_q.delete();
    if (kind == 0 || kind == 1) begin
      cmd_q.push_back(kind == 0 ? 8'h57 : 8'h52);
      for (int i = 3; i >= 0; i--) cmd_q.push_back(a[8*i +: 8]);
      if (kind == 0) for (int i = 3; i >= 0; i--) cmd_q.push_back(d[8*i +: 8]);
    end else begin
      bad = 8'($urandom);
      if (bad == 8'h57 || bad == 8'h52) bad = 8'h00;
      cmd_q.push_back(bad);
    end
  endtask

  task automatic clear_mon();
    tx_q.delete(); mon_wr_q.delete(); mon_addr_q.delete(); mon_wdata_q.delete();
    req_wait = 0;
  endtask

  task automatic applyStimulus(input logic [7:0] b, input int hold, input int gap);
    bif.rx_data = b;
    bif.rx_flag = 1'b1;
    repeat (hold) @(negedge clk);
    bif.rx_flag = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic run_txn(input int hold, input int gap, input int long_gap_idx);
    int n;
    clear_mon();
    build_model();
    foreach (cmd_q[i]) applyStimulus(cmd_q[i], hold, (i == long_gap_idx) ? 990 : gap);
    for (int c = 0; c < 6000; c++) begin
      if (tx_q.size() >= exp_tx_q.size() && !bif.tx_work && !bif.tx_en) break;
      @(negedge clk);
    end
    repeat (10) @(negedge clk);
    checkOutput("bus_count", 32'(mon_wr_q.size()), 32'(exp_bus));
    if (exp_bus && mon_wr_q.size() > 0) begin
      checkOutput("bus_kind", 32'(mon_wr_q[0]), 32'(exp_wr));
      checkOutput("bus_addr", mon_addr_q[0], exp_addr);
      if (exp_wr) checkOutput("bus_wdata", mon_wdata_q[0], exp_wdata);
    end
    checkOutput("req_wait", 32'(req_wait), (exp_bus && !gnt_tied) ? 32'(gnt_delay) : 32'd0);
    checkOutput("tx_count", 32'(tx_q.size()), 32'(exp_tx_q.size()));
    n = (tx_q.size() < exp_tx_q.size()) ? tx_q.size() : exp_tx_q.size();
    for (int i = 0; i < n; i++) checkOutput("tx_byte", 32'(tx_q[i]), 32'(exp_tx_q[i]));
  endtask

  initial begin
    bif.rx_flag = 1'b0;
    bif.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("rst_tx_en", 32'(bif.tx_en), 32'd0);
    checkOutput("rst_tx_data", 32'(bif.tx_data), 32'd0);
    checkOutput("rst_bus_req", 32'(bif.bus_req), 32'd0);
    checkOutput("rst_rd_wr", 32'({bif.rd, bif.wr}), 32'd0);
    checkOutput("rst_addr", bif.addr, 32'd0);
    checkOutput("rst_wdata", bif.wdata, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    gnt_tied = 1'b1;
    make_cmd(0, 32'h4000000C, 32'h000000A5);
    run_txn(2, 2, -1);

    rdata_val = 32'h0000003C;
    make_cmd(1, 32'h40000010, 32'h0);
    run_txn(2, 2, -1);

    gnt_tied = 1'b0; gnt_delay = 50;
    run_txn(2, 2, -1);

    gnt_tied = 1'b1;
    cmd_q.delete(); cmd_q.push_back(8'h13);
    run_txn(100, 2, -1);

    // Abandoned write must vanish after the idle limit.
    clear_mon();
    applyStimulus(8'h57, 2, 2);
    applyStimulus(8'h40, 2, 2);
    applyStimulus(8'h00, 2, 2);
    repeat (TO + 20) @(negedge clk);
    checkOutput("timeout_no_bus", 32'(mon_wr_q.size()), 32'd0);
    checkOutput("timeout_no_tx", 32'(tx_q.size()), 32'd0);
    rdata_val = $urandom;
    make_cmd(1, $urandom, 32'h0);
    run_txn(2, 2, -1);

    make_cmd(0, $urandom, $urandom);
    run_txn(1, 1, 1);

    tx_delay = 20; tx_busy = 300;
    rdata_val = $urandom;
    make_cmd(1, $urandom, 32'h0);
    run_txn(2, 2, -1);
    tx_delay = 0; tx_busy = 3;

    // Reset while waiting for the grant drops the request at once.
    gnt_tied = 1'b0; gnt_delay = 1000;
    make_cmd(1, $urandom, 32'h0);
    clear_mon();
    foreach (cmd_q[i]) applyStimulus(cmd_q[i], 2, 2);
    repeat (5) @(negedge clk);
    checkOutput("req_before_reset", 32'(bif.bus_req), 32'd1);
    #2 reset = 1'b0;
    #1;
    checkOutput("reset_drops_req", 32'(bif.bus_req), 32'd0);
    checkOutput("reset_no_strobe", 32'({bif.rd, bif.wr}), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    gnt_tied = 1'b1;
    repeat (20) @(negedge clk);
    checkOutput("reset_no_bus", 32'(mon_wr_q.size()), 32'd0);
    checkOutput("reset_no_tx", 32'(tx_q.size()), 32'd0);

    for (int t = 0; t < 12; t++) begin
      rdata_val = $urandom;
      gnt_tied  = 1'($urandom_range(0, 1));
      gnt_delay = int'($urandom_range(0, 12));
      tx_delay  = int'($urandom_range(0, 3));
      tx_busy   = int'($urandom_range(1, 6));
      make_cmd(int'($urandom_range(0, 2)), $urandom, $urandom);
      run_txn(int'($urandom_range(1, 4)), int'($urandom_range(1, 3)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
